// File: rtl/mem_access_unit_pkg.sv
// Shared types for the LC-3b MEM stage: opcode encoding and the MEM-stage
// control word consumed by mem_access_unit.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    op_br   = 4'd0,
    op_add  = 4'd1,
    op_ldb  = 4'd2,
    op_stb  = 4'd3,
    op_jsr  = 4'd4,
    op_and  = 4'd5,
    op_ldr  = 4'd6,
    op_str  = 4'd7,
    op_rti  = 4'd8,
    op_not  = 4'd9,
    op_ldi  = 4'd10,
    op_sti  = 4'd11,
    op_jmp  = 4'd12,
    op_shf  = 4'd13,
    op_lea  = 4'd14,
    op_trap = 4'd15
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       read_memory;
    logic       write_memory;
  } lc3b_control;

endpackage

// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage access unit: sequences direct (LDR/LDB/STR/STB) and
// indirect (LDI/STI) data-memory accesses, stalls the pipeline meanwhile.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   ctrl_in, valid_in            MEM-stage control word and its valid
//   addr_in, wdata_in            effective address, store data
//   dmem_resp, dmem_rdata        memory completion pulse and read word
//   dmem_read/write/addr/wdata/byte_enable  registered memory request
//   stall_out                    combinational pipeline freeze
//   rdata_out, done_out          load result, one-cycle completion pulse
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  lc3b_control ctrl_in,
  input  logic        valid_in,
  input  logic [15:0] addr_in,
  input  logic [15:0] wdata_in,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic        stall_out,
  output logic [15:0] rdata_out,
  output logic        done_out
);

  localparam int unsigned DW = 16;

  typedef enum logic [2:0] {IDLE, ACCESS, IND_PTR, IND_ACC, DONE} state_t;

  state_t     state, state_next;
  lc3b_opcode lat_opcode;
  logic [DW-1:0] lat_addr, lat_wdata, pointer;

  logic          mem_op, ind_in, lat_store;
  logic          latch_en, ptr_en, resp_final;
  logic          read_next, write_next;
  logic [DW-1:0] addr_next, wdata_next;
  logic [1:0]    be_next;

  assign mem_op    = valid_in & (ctrl_in.read_memory | ctrl_in.write_memory);
  assign ind_in    = (ctrl_in.opcode == op_ldi) || (ctrl_in.opcode == op_sti);
  assign lat_store = (lat_opcode == op_sti);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state, stall and next request; request outputs hold by default
  always_comb begin
    state_next = state;
    latch_en   = 1'b0;
    ptr_en     = 1'b0;
    resp_final = 1'b0;
    stall_out  = 1'b0;
    read_next  = 1'b0;
    write_next = 1'b0;
    addr_next  = dmem_addr;
    wdata_next = dmem_wdata;
    be_next    = dmem_byte_enable;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_out = 1'b1;
          latch_en  = 1'b1;
          if (ind_in) begin
            state_next = IND_PTR;
            read_next  = 1'b1;
            addr_next  = {addr_in[15:1], 1'b0};
            wdata_next = '0;
            be_next    = 2'b11;
          end else begin
            state_next = ACCESS;
            case (ctrl_in.opcode)
              op_ldb: begin
                read_next  = 1'b1;
                addr_next  = addr_in;
                wdata_next = '0;
                be_next    = 2'b11;
              end
              op_stb: begin
                write_next = 1'b1;
                addr_next  = addr_in;
                wdata_next = {wdata_in[7:0], wdata_in[7:0]};
                be_next    = addr_in[0] ? 2'b10 : 2'b01;
              end
              op_str: begin
                write_next = 1'b1;
                addr_next  = {addr_in[15:1], 1'b0};
                wdata_next = wdata_in;
                be_next    = 2'b11;
              end
              default: begin
                read_next  = 1'b1;
                addr_next  = {addr_in[15:1], 1'b0};
                wdata_next = '0;
                be_next    = 2'b11;
              end
            endcase
          end
        end
      end
      ACCESS: begin
        stall_out  = 1'b1;
        read_next  = dmem_read;
        write_next = dmem_write;
        if (dmem_resp) begin
          state_next = DONE;
          resp_final = 1'b1;
          read_next  = 1'b0;
          write_next = 1'b0;
        end
      end
      IND_PTR: begin
        stall_out = 1'b1;
        read_next = 1'b1;
        if (dmem_resp) begin
          // Second request issues straight from the returned pointer word
          state_next = IND_ACC;
          ptr_en     = 1'b1;
          read_next  = ~lat_store;
          write_next = lat_store;
          addr_next  = {dmem_rdata[15:1], 1'b0};
          wdata_next = lat_store ? lat_wdata : '0;
          be_next    = 2'b11;
        end
      end
      IND_ACC: begin
        stall_out  = 1'b1;
        read_next  = dmem_read;
        write_next = dmem_write;
        addr_next  = {pointer[15:1], 1'b0};
        if (dmem_resp) begin
          state_next = DONE;
          resp_final = 1'b1;
          read_next  = 1'b0;
          write_next = 1'b0;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered request, latches and result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem_read        <= 1'b0;
      dmem_write       <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      dmem_byte_enable <= '0;
      rdata_out        <= '0;
      done_out         <= 1'b0;
      lat_opcode       <= op_br;
      lat_addr         <= '0;
      lat_wdata        <= '0;
      pointer          <= '0;
    end else begin
      dmem_read        <= read_next;
      dmem_write       <= write_next;
      dmem_addr        <= addr_next;
      dmem_wdata       <= wdata_next;
      dmem_byte_enable <= be_next;
      done_out         <= (state_next == DONE);
      if (latch_en) begin
        lat_opcode <= ctrl_in.opcode;
        lat_addr   <= addr_in;
        lat_wdata  <= wdata_in;
      end
      if (ptr_en) pointer <= dmem_rdata;
      if (resp_final) begin
        case (lat_opcode)
          op_ldb:                 rdata_out <= {8'h00, lat_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]};
          op_stb, op_str, op_sti: rdata_out <= '0;
          default:                rdata_out <= dmem_rdata;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of direct accesses applied
// back-to-back, plus hand sequences for LDI/STI and reset mid-access.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk, reset_n;
  lc3b_control ctrl_in;
  logic        valid_in, dmem_resp;
  logic [15:0] addr_in, wdata_in, dmem_rdata;
  logic        dmem_read, dmem_write, stall_out, done_out;
  logic [15:0] dmem_addr, dmem_wdata, rdata_out;
  logic [1:0]  dmem_byte_enable;

  int n_vec  = 0;
  int n_miss = 0;

  mem_access_unit dut (
    .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .dmem_resp(dmem_resp),
    .dmem_rdata(dmem_rdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .stall_out(stall_out),
    .rdata_out(rdata_out), .done_out(done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    lc3b_opcode  op;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          waits;
    logic [15:0] rdata;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic [1:0]  e_be;
    logic        e_wr;
    logic [15:0] e_out;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (dmem_read === 1'b1 && dmem_write === 1'b1) begin
      n_miss++;
      $display("FAIL rd_wr_both: got read=1 write=1 expected not both at %0t", $time);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input lc3b_opcode op, input logic [15:0] a, input logic [15:0] w);
    logic st;
    st = (op == op_str) || (op == op_stb) || (op == op_sti);
    ctrl_in.opcode       = op;
    ctrl_in.read_memory  = !st;
    ctrl_in.write_memory = st;
    valid_in = 1'b1;
    addr_in  = a;
    wdata_in = w;
  endtask

  // Scramble inputs after acceptance so only latched values can be used
  task automatic drop_op();
    valid_in       = 1'b0;
    ctrl_in.opcode = op_add;
    addr_in        = 16'hFFFF;
    wdata_in       = 16'hDEAD;
  endtask

  // One response phase: holds checked each cycle, resp on the last
  task automatic resp_phase(input string tag, input int waits, input logic [15:0] rd,
                            input logic [15:0] e_addr, inout int stalls);
    for (int k = 0; k <= waits; k++) begin
      chk({tag, "_hold_addr"}, dmem_addr, e_addr);
      if (k == waits) begin
        dmem_resp  = 1'b1;
        dmem_rdata = rd;
      end else begin
        dmem_rdata = 16'($urandom());
      end
      stalls += int'(stall_out);
      next_cycle();
      dmem_resp = 1'b0;
    end
  endtask

  task automatic run_direct(input int idx, input vec_t v);
    int    stalls;
    string t;
    t = $sformatf("v%0d", idx);
    drive_op(v.op, v.addr, v.wdata);
    #1;
    chk({t, "_idle_stall"}, 16'(stall_out), 16'd1);
    stalls = 1;
    next_cycle();
    drop_op();
    chk({t, "_read"},  16'(dmem_read),  16'(!v.e_wr));
    chk({t, "_write"}, 16'(dmem_write), 16'(v.e_wr));
    chk({t, "_addr"},  dmem_addr, v.e_addr);
    chk({t, "_be"},    16'(dmem_byte_enable), 16'(v.e_be));
    if (v.e_wr) chk({t, "_wdata"}, dmem_wdata, v.e_wdata);
    resp_phase(t, v.waits, v.rdata, v.e_addr, stalls);
    chk({t, "_done"},     16'(done_out), 16'd1);
    chk({t, "_done_stall"}, 16'(stall_out), 16'd0);
    chk({t, "_done_req"}, 16'(dmem_read | dmem_write), 16'd0);
    chk({t, "_rdata"},    rdata_out, v.e_out);
    chk({t, "_stalls"},   16'(stalls), 16'(v.waits + 2));
    next_cycle();
    chk({t, "_done_pulse"}, 16'(done_out), 16'd0);
  endtask

  task automatic run_ind(input string t, input lc3b_opcode op, input logic [15:0] a,
                         input logic [15:0] w, input logic [15:0] ptr, input int w1,
                         input int w2, input logic [15:0] rd, input logic [15:0] e_out);
    int   stalls;
    logic st;
    st = (op == op_sti);
    drive_op(op, a, w);
    #1;
    chk({t, "_idle_stall"}, 16'(stall_out), 16'd1);
    stalls = 1;
    next_cycle();
    drop_op();
    chk({t, "_p_read"},  16'(dmem_read),  16'd1);
    chk({t, "_p_write"}, 16'(dmem_write), 16'd0);
    chk({t, "_p_addr"},  dmem_addr, {a[15:1], 1'b0});
    chk({t, "_p_be"},    16'(dmem_byte_enable), 16'd3);
    resp_phase({t, "_p"}, w1, ptr, {a[15:1], 1'b0}, stalls);
    chk({t, "_a_read"},  16'(dmem_read),  16'(!st));
    chk({t, "_a_write"}, 16'(dmem_write), 16'(st));
    chk({t, "_a_addr"},  dmem_addr, {ptr[15:1], 1'b0});
    chk({t, "_a_be"},    16'(dmem_byte_enable), 16'd3);
    if (st) chk({t, "_a_wdata"}, dmem_wdata, w);
    resp_phase({t, "_a"}, w2, rd, {ptr[15:1], 1'b0}, stalls);
    chk({t, "_done"},     16'(done_out), 16'd1);
    chk({t, "_done_req"}, 16'(dmem_read | dmem_write), 16'd0);
    chk({t, "_rdata"},    rdata_out, e_out);
    chk({t, "_stalls"},   16'(stalls), 16'(w1 + w2 + 3));
    next_cycle();
    chk({t, "_done_pulse"}, 16'(done_out), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           op      addr      wdata    w  rdata     e_addr    e_wdata   be     wr    e_out
    tbl[0] = '{op_ldr, 16'h3005, 16'h0000, 3, 16'hBEEF, 16'h3004, 16'h0000, 2'b11, 1'b0, 16'hBEEF};
    tbl[1] = '{op_ldb, 16'h3005, 16'h0000, 1, 16'hA15A, 16'h3005, 16'h0000, 2'b11, 1'b0, 16'h00A1};
    tbl[2] = '{op_ldb, 16'h3004, 16'h0000, 0, 16'hA15A, 16'h3004, 16'h0000, 2'b11, 1'b0, 16'h005A};
    tbl[3] = '{op_stb, 16'h4001, 16'h12C3, 2, 16'h7777, 16'h4001, 16'hC3C3, 2'b10, 1'b1, 16'h0000};
    tbl[4] = '{op_stb, 16'h4000, 16'h12C3, 0, 16'h7777, 16'h4000, 16'hC3C3, 2'b01, 1'b1, 16'h0000};
    tbl[5] = '{op_str, 16'h4001, 16'h55AA, 1, 16'h7777, 16'h4000, 16'h55AA, 2'b11, 1'b1, 16'h0000};

    reset_n    = 1'b0;
    valid_in   = 1'b0;
    ctrl_in    = '{opcode: op_br, read_memory: 1'b0, write_memory: 1'b0};
    addr_in    = '0;
    wdata_in   = '0;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    #12;
    chk("rst_read",  16'(dmem_read),  16'd0);
    chk("rst_write", 16'(dmem_write), 16'd0);
    chk("rst_addr",  dmem_addr, 16'h0000);
    chk("rst_done",  16'(done_out), 16'd0);
    chk("rst_stall", 16'(stall_out), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();

    // Direct accesses, each presented the cycle after the previous DONE
    for (int i = 0; i < 6; i++) run_direct(i, tbl[i]);

    // Indirect load with wait states, then indirect store with zero-wait responses
    run_ind("ldi", op_ldi, 16'h5000, 16'h0000, 16'h6003, 1, 2, 16'h0042, 16'h0042);
    run_ind("sti", op_sti, 16'h7001, 16'hBEEF, 16'h8005, 0, 0, 16'h1111, 16'h0000);
    run_ind("ldi2", op_ldi, 16'h5001, 16'h0000, 16'h9ABC, 0, 1, 16'hCAFE, 16'hCAFE);

    // Reset asserted while in IND_ACC
    drive_op(op_ldi, 16'h5000, 16'h0000);
    next_cycle();
    drop_op();
    dmem_resp  = 1'b1;
    dmem_rdata = 16'h1235;
    next_cycle();
    dmem_resp = 1'b0;
    chk("ar_in_acc_read", 16'(dmem_read), 16'd1);
    chk("ar_in_acc_addr", dmem_addr, 16'h1234);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_read",  16'(dmem_read),  16'd0);
    chk("ar_write", 16'(dmem_write), 16'd0);
    chk("ar_addr",  dmem_addr, 16'h0000);
    chk("ar_wdata", dmem_wdata, 16'h0000);
    chk("ar_be",    16'(dmem_byte_enable), 16'd0);
    chk("ar_rdata", rdata_out, 16'h0000);
    chk("ar_done",  16'(done_out), 16'd0);
    chk("ar_stall", 16'(stall_out), 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    dmem_resp  = 1'b1;
    dmem_rdata = 16'hFFFF;
    next_cycle();
    dmem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stale_done",  16'(done_out), 16'd0);
      chk("stale_req",   16'(dmem_read | dmem_write), 16'd0);
      chk("stale_stall", 16'(stall_out), 16'd0);
      next_cycle();
    end

    // Normal operation resumes after reset
    run_direct(10, tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
